// File: rtl/ad9866_pkg.sv
// ad9866_pkg: shared types, constants and the default init table for the AD9866 SPI controller
package ad9866_pkg;
  localparam int SPI_FRAME_W = 16;
  localparam logic [4:0] ADDR_RXGAIN = 5'h0A;
  localparam logic [4:0] ADDR_TXGAIN = 5'h11;
  typedef struct packed {
    logic       wr_en;
    logic [7:0] data;
  } init_entry_t;
  typedef enum logic [2:0] {PHY_IDLE, PHY_SETUP, PHY_LOW, PHY_HIGH, PHY_GAP} phy_state_t;
  typedef enum logic {SEQ_INIT, SEQ_RUN} seq_state_t;
  localparam init_entry_t [19:0] INIT_DEFAULT = {
    9'h000, 9'h000,
    9'h100,
    9'h000, 9'h000, 9'h000,
    9'h101,
    9'h141,
    9'h120,
    9'h000, 9'h000,
    9'h14B,
    9'h121,
    9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000,
    9'h180
  };
  function automatic logic [SPI_FRAME_W-1:0] spi_frame(input logic rd, input logic [4:0] addr,
                                                       input logic [7:0] data);
    return {rd, 2'b00, addr, rd ? 8'h00 : data};
  endfunction
endpackage

// File: rtl/ad9866_spi_phy.sv
// ad9866_spi_phy: one 16-bit SPI frame per start, full-duplex shift, programmable SCLK and gap
module ad9866_spi_phy
  import ad9866_pkg::*;
#(
  parameter int CLK_DIV = 1,
  parameter int GAP     = 2
)(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start_i,
  input  logic [SPI_FRAME_W-1:0] frame_i,
  input  logic                   sdo_i,
  output logic                   sclk_o,
  output logic                   sen_n_o,
  output logic                   sdio_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [7:0]             rdata_o
);
  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP - 1);
  phy_state_t             state_q, state_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [SPI_FRAME_W-1:0] shift_q, shift_d;
  logic [3:0]             bit_q, bit_d;
  logic                   div_end;
  assign div_end = cnt_q == DIV_LAST;
  // frame FSM: SETUP, then 16 HIGH phases separated by LOW phases, then the sen_n-high gap
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    shift_d = shift_q;
    bit_d   = bit_q;
    case (state_q)
      PHY_IDLE: begin
        cnt_d = '0;
        if (start_i) begin
          state_d = PHY_SETUP;
          shift_d = frame_i;
          bit_d   = '0;
        end
      end
      PHY_SETUP: if (div_end) begin
        cnt_d   = '0;
        state_d = PHY_HIGH;
      end
      PHY_HIGH: if (div_end) begin
        cnt_d   = '0;
        shift_d = {shift_q[SPI_FRAME_W-2:0], sdo_i};
        bit_d   = bit_q + 4'd1;
        state_d = (bit_q == 4'd15) ? PHY_GAP : PHY_LOW;
      end
      PHY_LOW: if (div_end) begin
        cnt_d   = '0;
        state_d = PHY_HIGH;
      end
      PHY_GAP: if (cnt_q == GAP_LAST) begin
        cnt_d   = '0;
        state_d = PHY_IDLE;
      end
      default: state_d = PHY_IDLE;
    endcase
  end
  // frame state register; reset drops any partial frame
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= PHY_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
    end
  end
  assign sclk_o  = state_q == PHY_HIGH;
  assign sen_n_o = !(state_q inside {PHY_SETUP, PHY_LOW, PHY_HIGH});
  assign sdio_o  = !sen_n_o & shift_q[SPI_FRAME_W-1];
  assign busy_o  = state_q != PHY_IDLE;
  assign done_o  = (state_q == PHY_GAP) && (cnt_q == '0);
  assign rdata_o = shift_q[7:0];
endmodule

// File: rtl/ad9866_spi_ctrl.sv
// ad9866_spi_ctrl: init-table sequencer plus host/RX-gain/TX-gain arbitration onto the SPI phy
module ad9866_spi_ctrl
  import ad9866_pkg::*;
#(
  parameter int                        NREGS       = 20,
  parameter init_entry_t [NREGS-1:0]   INIT_TABLE  = INIT_DEFAULT,
  parameter int                        CLK_DIV     = 1,
  parameter int                        GAP         = 2,
  parameter logic [4:0]                RXGAIN_ADDR = ADDR_RXGAIN,
  parameter logic [4:0]                TXGAIN_ADDR = ADDR_TXGAIN
)(
  input  logic       clk,
  input  logic       reset_n,
  output logic       sclk,
  output logic       sen_n,
  output logic       sdio,
  input  logic       sdo,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rd,
  input  logic [4:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  input  logic [5:0] rx_gain,
  input  logic [3:0] tx_gain,
  input  logic       reinit,
  output logic       init_done,
  output logic       busy
);
  seq_state_t             seq_q, seq_d;
  logic [5:0]             idx_q, idx_d;
  logic                   init_done_q, init_done_d;
  logic [5:0]             rx_sh_q, rx_sh_d;
  logic [3:0]             tx_sh_q, tx_sh_d;
  logic                   rd_q, rd_d;
  logic                   reinit_q, reinit_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [7:0]             rsp_data_q, rsp_data_d;
  logic                   phy_start, phy_busy, phy_done;
  logic [SPI_FRAME_W-1:0] phy_frame;
  logic [7:0]             phy_rdata;
  init_entry_t            entry;
  assign entry     = INIT_TABLE[idx_q[4:0]];
  assign cmd_ready = (seq_q == SEQ_RUN) && !phy_busy && !reinit_q;
  // sequencer and arbiter: decisions are only taken while the phy is idle
  always_comb begin
    seq_d       = seq_q;
    idx_d       = idx_q;
    init_done_d = init_done_q;
    rx_sh_d     = rx_sh_q;
    tx_sh_d     = tx_sh_q;
    rd_d        = rd_q;
    reinit_d    = reinit_q | reinit;
    phy_start   = 1'b0;
    phy_frame   = '0;
    rsp_valid_d = phy_done & rd_q;
    rsp_data_d  = rsp_valid_d ? phy_rdata : rsp_data_q;
    if (!phy_busy) begin
      if (seq_q == SEQ_INIT) begin
        if (idx_q == 6'(NREGS)) begin
          seq_d       = SEQ_RUN;
          init_done_d = 1'b1;
        end else begin
          idx_d     = idx_q + 6'd1;
          rd_d      = 1'b0;
          phy_start = entry.wr_en;
          phy_frame = spi_frame(1'b0, idx_q[4:0], entry.data);
          if (!entry.wr_en && idx_q == 6'(NREGS - 1)) begin
            seq_d       = SEQ_RUN;
            init_done_d = 1'b1;
          end
        end
      end else if (reinit_q) begin
        seq_d       = SEQ_INIT;
        idx_d       = '0;
        init_done_d = 1'b0;
        reinit_d    = 1'b0;
      end else if (cmd_valid) begin
        phy_start = 1'b1;
        phy_frame = spi_frame(cmd_rd, cmd_addr, cmd_wdata);
        rd_d      = cmd_rd;
      end else if (rx_gain != rx_sh_q) begin
        phy_start = 1'b1;
        phy_frame = spi_frame(1'b0, RXGAIN_ADDR, {2'b01, rx_gain});
        rx_sh_d   = rx_gain;
        rd_d      = 1'b0;
      end else if (tx_gain != tx_sh_q) begin
        phy_start = 1'b1;
        phy_frame = spi_frame(1'b0, TXGAIN_ADDR, {4'h0, tx_gain});
        tx_sh_d   = tx_gain;
        rd_d      = 1'b0;
      end
    end
  end
  // sequencer state; gain shadows start at all-ones so both gains are sent after init
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seq_q       <= SEQ_INIT;
      idx_q       <= '0;
      init_done_q <= 1'b0;
      rx_sh_q     <= '1;
      tx_sh_q     <= '1;
      rd_q        <= 1'b0;
      reinit_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      seq_q       <= seq_d;
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
      rx_sh_q     <= rx_sh_d;
      tx_sh_q     <= tx_sh_d;
      rd_q        <= rd_d;
      reinit_q    <= reinit_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end
  ad9866_spi_phy #(.CLK_DIV(CLK_DIV), .GAP(GAP)) u_phy (
    .clk     (clk),
    .reset_n (reset_n),
    .start_i (phy_start),
    .frame_i (phy_frame),
    .sdo_i   (sdo),
    .sclk_o  (sclk),
    .sen_n_o (sen_n),
    .sdio_o  (sdio),
    .busy_o  (phy_busy),
    .done_o  (phy_done),
    .rdata_o (phy_rdata)
  );
  assign busy      = phy_busy;
  assign init_done = init_done_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_ad9866_spi_ctrl.sv
// tb_ad9866_spi_ctrl: directed self-checking bench for the AD9866 SPI controller
module tb_ad9866_spi_ctrl;
  logic       clk = 1'b0, reset_n = 1'b0, cmd_valid = 1'b0, cmd_rd = 1'b0, reinit = 1'b0;
  logic [4:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic [5:0] rx_gain = 6'h15;
  logic [3:0] tx_gain = 4'h7;
  logic       sclk, sen_n, sdio, sdo, cmd_ready, rsp_valid, init_done, busy;
  logic [7:0] rsp_data;
  logic       sclk3, sen_n3, sdio3, cmd_ready3, rsp_valid3, init_done3, busy3;
  logic       sdo3 = 1'b0;
  logic [7:0] rsp_data3;
  int         checks = 0, errors = 0;
  logic [15:0] frames[$];
  logic [15:0] cap = '0;
  logic [4:0]  rises = '0;
  logic [15:0] resp_word = 16'h00A5;
  logic [15:0] exp_init [7];
  int run3 = 0, first_len3 = 0, hi3 = 0, first_hi3 = 0, r3 = 0, first_r3 = 0;

  always #5 clk = ~clk;

  ad9866_spi_ctrl u_dut (
    .clk(clk), .reset_n(reset_n), .sclk(sclk), .sen_n(sen_n), .sdio(sdio), .sdo(sdo),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd(cmd_rd), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rx_gain(rx_gain),
    .tx_gain(tx_gain), .reinit(reinit), .init_done(init_done), .busy(busy)
  );

  ad9866_spi_ctrl #(.CLK_DIV(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .sclk(sclk3), .sen_n(sen_n3), .sdio(sdio3), .sdo(sdo3),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready3), .cmd_rd(cmd_rd), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid3), .rsp_data(rsp_data3), .rx_gain(rx_gain),
    .tx_gain(tx_gain), .reinit(reinit), .init_done(init_done3), .busy(busy3)
  );

  // codec model: drives bit (15-k) of resp_word while the k-th sclk high phase is active
  assign sdo = (rises == 5'd0) ? 1'b0 : resp_word[4'(5'd16 - rises)];

  // frame capture on the codec side: shift sdio on each sclk rise, log the frame when sen_n rises
  always @(posedge sclk or posedge sen_n)
    if (sen_n) begin
      if (rises != 5'd0) frames.push_back(cap);
      rises <= 5'd0;
    end else begin
      cap   <= {cap[14:0], sdio};
      rises <= rises + 5'd1;
    end

  // CLK_DIV=3 instance: length of the first busy run and of the first sclk high phase
  always @(posedge clk) begin
    if (busy3) run3 <= run3 + 1;
    else begin
      if (run3 != 0 && first_len3 == 0) first_len3 <= run3;
      run3 <= 0;
    end
    if (sclk3) hi3 <= hi3 + 1;
    else begin
      if (hi3 != 0 && first_hi3 == 0) first_hi3 <= hi3;
      hi3 <= 0;
    end
  end

  // CLK_DIV=3 instance: sclk rising edges in the first frame
  always @(posedge sclk3 or posedge sen_n3)
    if (sen_n3) begin
      if (r3 != 0 && first_r3 == 0) first_r3 <= r3;
      r3 <= 0;
    end else r3 <= r3 + 1;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!cmd_ready && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("cmd_ready_wait", 16'(cmd_ready), 16'd1);
  endtask

  task automatic send(input logic rd, input logic [4:0] a, input logic [7:0] d);
    wait_ready();
    cmd_rd    = rd;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int t = 0;
    while (frames.size() < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("frame_wait", 16'(frames.size() >= n), 16'd1);
  endtask

  initial begin
    int n, t, base, viol;
    exp_init = '{16'h0080, 16'h0721, 16'h084B, 16'h0B20, 16'h0C41, 16'h0D01, 16'h1100};
    tick(3);
    check("rst_outs", 16'({sclk, sen_n, sdio, cmd_ready, rsp_valid, init_done, busy}), 16'b0100000);
    check("rst_rsp_data", 16'(rsp_data), 16'h0000);
    check("rst_outs_div3", 16'({sclk3, sen_n3, sdio3, cmd_ready3, rsp_valid3, init_done3, busy3}), 16'b0100000);
    check("rst_rsp_data_div3", 16'(rsp_data3), 16'h0000);
    reset_n = 1'b1;
    t = 0;
    while (!busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    n = 0;
    while (busy && n < 1000) begin
      n++;
      @(negedge clk);
    end
    check("frame_len_div1", 16'(n), 16'd34);
    t = 0;
    while (!init_done && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("init_done_rise", 16'(init_done), 16'd1);
    check("init_frame_count", 16'(frames.size()), 16'd7);
    check("init_done_idle", 16'(busy), 16'd0);
    for (int i = 0; i < 7; i++) check("init_frame", frames[i], exp_init[i]);
    wait_frames(9);
    check("rx_gain_frame", frames[7], 16'h0A55);
    check("tx_gain_frame", frames[8], 16'h1107);
    check("div3_frame_len", 16'(first_len3), 16'd98);
    check("div3_sclk_high", 16'(first_hi3), 16'd3);
    check("div3_rises", 16'(first_r3), 16'd16);
    send(1'b1, 5'h05, 8'hFF);
    t = 0;
    while (!rsp_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("rsp_valid", 16'(rsp_valid), 16'd1);
    check("rsp_data", 16'(rsp_data), 16'h00A5);
    check("read_frame", frames[frames.size() - 1], 16'h8500);
    @(negedge clk);
    check("rsp_pulse_width", 16'(rsp_valid), 16'd0);
    check("rsp_data_hold", 16'(rsp_data), 16'h00A5);
    wait_ready();
    base = frames.size();
    cmd_rd = 1'b0;
    cmd_addr = 5'h03;
    cmd_wdata = 8'h5A;
    rx_gain = 6'h10;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    viol = 0;
    t = 0;
    while ((frames.size() < base + 2 || busy) && t < 500) begin
      if (busy && cmd_ready) viol++;
      @(negedge clk);
      t++;
    end
    check("ready_low_while_busy", 16'(viol), 16'd0);
    check("cmd_before_gain", frames[base], 16'h035A);
    check("gain_after_cmd", frames[base + 1], 16'h0A50);
    base = frames.size();
    send(1'b0, 5'h04, 8'h11);
    tick(5);
    check("busy_midframe", 16'(busy), 16'd1);
    rx_gain = 6'h22;
    tick(5);
    rx_gain = 6'h23;
    wait_frames(base + 2);
    tick(60);
    check("gain_extra_count", 16'(frames.size()), 16'(base + 2));
    check("gain_host_frame", frames[base], 16'h0411);
    check("gain_latest_value", frames[base + 1], 16'h0A63);
    base = frames.size();
    send(1'b0, 5'h06, 8'h77);
    tick(3);
    reinit = 1'b1;
    @(negedge clk);
    reinit = 1'b0;
    check("reinit_frame_continues", 16'({busy, init_done}), 16'b11);
    t = 0;
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("reinit_blocks_ready", 16'(cmd_ready), 16'd0);
    check("reinit_host_frame", frames[base], 16'h0677);
    t = 0;
    while (init_done && t < 10) begin
      @(negedge clk);
      t++;
    end
    check("init_done_fall", 16'(init_done), 16'd0);
    t = 0;
    while (!init_done && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("replay_done", 16'(init_done), 16'd1);
    check("replay_count", 16'(frames.size()), 16'(base + 8));
    for (int i = 0; i < 7; i++) check("replay_frame", frames[base + 1 + i], exp_init[i]);
    send(1'b0, 5'h02, 8'h33);
    t = 0;
    while (!(sclk && !sen_n) && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("midframe_sclk_high", 16'({sclk, sen_n}), 16'b10);
    reset_n = 1'b0;
    #1;
    check("async_reset", 16'({sen_n, sclk, sdio, busy, init_done, cmd_ready}), 16'b100000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
